// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a req/ready instruction
// memory and buffers fetched words in a small in-order queue feeding IF/ID.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_instru,
   output logic        if_valid,
   output logic [31:0] if_instru,
   output logic [31:0] if_pc
);

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t        state_r;
   logic [31:0]   pc_r;
   logic [31:0]   hold_addr_r;
   logic [CW-1:0] count_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [31:0]   q_instru_r [DEPTH];
   logic [31:0]   q_pc_r     [DEPTH];

   logic accept_s;
   logic push_s;
   logic pop_s;

   // Memory request decode; DISCARD keeps the abandoned address on the bus until it completes
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_r;
      case (state_r)
         FETCH: begin
            imem_req  = (count_r < FULL);
            imem_addr = pc_r;
         end
         DISCARD: begin
            imem_req  = 1'b1;
            imem_addr = hold_addr_r;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = pc_r;
         end
      endcase
   end

   // Queue handshake and head presentation
   always_comb begin
      accept_s = (state_r == FETCH) && imem_req && imem_ready;
      push_s   = accept_s && !branch_taken;
      if_valid = (count_r != {CW{1'b0}});
      pop_s    = if_valid && !freeze && !branch_taken;
      if (if_valid) begin
         if_instru = q_instru_r[rd_ptr_r];
         if_pc     = q_pc_r[rd_ptr_r];
      end else begin
         if_instru = 32'd0;
         if_pc     = 32'd0;
      end
   end

   // Sequencer state, fetch PC and instruction queue storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         pc_r        <= RESET_PC;
         hold_addr_r <= RESET_PC;
         count_r     <= {CW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         wr_ptr_r    <= {PW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            q_instru_r[i] <= 32'd0;
            q_pc_r[i]     <= 32'd0;
         end
      end else if (branch_taken) begin
         // Redirect overrides everything: flush queue, retarget, drop any word arriving now
         pc_r     <= branch_addr;
         count_r  <= {CW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         case (state_r)
            FETCH: begin
               if (imem_req && !imem_ready) begin
                  state_r     <= DISCARD;
                  hold_addr_r <= pc_r;
               end else begin
                  state_r <= FETCH;
               end
            end
            DISCARD: state_r <= imem_ready ? FETCH : DISCARD;
            default: state_r <= FETCH;
         endcase
      end else begin
         case (state_r)
            IDLE:    state_r <= FETCH;
            FETCH:   state_r <= FETCH;
            DISCARD: state_r <= imem_ready ? FETCH : DISCARD;
            default: state_r <= IDLE;
         endcase
         if (push_s) begin
            q_instru_r[wr_ptr_r] <= imem_instru;
            q_pc_r[wr_ptr_r]     <= pc_r + 32'd4;
            wr_ptr_r             <= wr_ptr_r + 1'b1;
            pc_r                 <= pc_r + 32'd4;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: table of per-cycle vectors against a
// behavioural wait-state instruction memory, plus reset/sync sequences.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_instru;
   logic        if_valid;
   logic [31:0] if_instru;
   logic [31:0] if_pc;

   int checks = 0;
   int errors = 0;

   if_fetch_ctrl #(.RESET_PC(32'd0), .DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .freeze      (freeze),
      .branch_taken(branch_taken),
      .branch_addr (branch_addr),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_instru (imem_instru),
      .if_valid    (if_valid),
      .if_instru   (if_instru),
      .if_pc       (if_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hE3A0_1000;
   endfunction

   // Instruction memory: ready after mem_wait stalled cycles of a held request
   int unsigned mem_wait = 0;
   int unsigned mem_cnt  = 0;
   assign imem_ready  = imem_req && (mem_cnt >= mem_wait);
   assign imem_instru = instr_of(imem_addr);
   always @(posedge clk) begin
      if (imem_req && !imem_ready) mem_cnt <= mem_cnt + 1;
      else                         mem_cnt <= 0;
   end

   typedef struct packed {
      logic        fr;
      logic        br;
      logic [31:0] baddr;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t rows [49];

   function automatic vec_t mk(input logic fr, input logic br, input logic [31:0] baddr,
                               input logic req, input logic [31:0] addr,
                               input logic valid, input logic [31:0] pc);
      vec_t v;
      v.fr = fr; v.br = br; v.baddr = baddr;
      v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " imem_req"},  {31'd0, imem_req}, 32'd0);
      chk({tag, " imem_addr"}, imem_addr, 32'd0);
      chk({tag, " if_valid"},  {31'd0, if_valid}, 32'd0);
      chk({tag, " if_instru"}, if_instru, 32'd0);
      chk({tag, " if_pc"},     if_pc, 32'd0);
   endtask

   // Assert reset (asynchronously, mid-cycle), check it, release just after a rising edge
   task automatic apply_reset(input string tag);
      freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
      rst_n = 1'b0;
      #1;
      chk_reset(tag);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic run_rows(input int first, input int last);
      logic [31:0] exp_i;
      for (int i = first; i <= last; i++) begin
         @(negedge clk);
         freeze       = rows[i].fr;
         branch_taken = rows[i].br;
         branch_addr  = rows[i].baddr;
         #1;
         exp_i = rows[i].valid ? instr_of(rows[i].pc - 32'd4) : 32'd0;
         chk($sformatf("row%0d imem_req", i),  {31'd0, imem_req}, {31'd0, rows[i].req});
         chk($sformatf("row%0d imem_addr", i), imem_addr, rows[i].addr);
         chk($sformatf("row%0d if_valid", i),  {31'd0, if_valid}, {31'd0, rows[i].valid});
         chk($sformatf("row%0d if_pc", i),     if_pc, rows[i].pc);
         chk($sformatf("row%0d if_instru", i), if_instru, exp_i);
      end
   endtask

   initial begin
      logic found;
      // Streaming, freeze-fill and zero-wait redirects (memory always ready)
      rows[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
      rows[1]  = mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
      rows[2]  = mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h4);
      rows[3]  = mk(0, 0, 32'h0,        1, 32'h8,        1, 32'h8);
      rows[4]  = mk(0, 0, 32'h0,        1, 32'hC,        1, 32'hC);
      rows[5]  = mk(1, 0, 32'h0,        1, 32'h10,       1, 32'h10);
      rows[6]  = mk(1, 0, 32'h0,        0, 32'h14,       1, 32'h10);
      rows[7]  = mk(1, 0, 32'h0,        0, 32'h14,       1, 32'h10);
      rows[8]  = mk(1, 0, 32'h0,        0, 32'h14,       1, 32'h10);
      rows[9]  = mk(1, 0, 32'h0,        0, 32'h14,       1, 32'h10);
      rows[10] = mk(0, 0, 32'h0,        0, 32'h14,       1, 32'h10);
      rows[11] = mk(0, 0, 32'h0,        1, 32'h14,       1, 32'h14);
      rows[12] = mk(0, 0, 32'h0,        1, 32'h18,       1, 32'h18);
      rows[13] = mk(1, 0, 32'h0,        1, 32'h1C,       1, 32'h1C);
      rows[14] = mk(0, 1, 32'h90,       0, 32'h20,       1, 32'h1C);
      rows[15] = mk(0, 0, 32'h0,        1, 32'h90,       0, 32'h0);
      rows[16] = mk(0, 0, 32'h0,        1, 32'h94,       1, 32'h94);
      rows[17] = mk(0, 1, 32'h100,      1, 32'h98,       1, 32'h98);
      rows[18] = mk(0, 0, 32'h0,        1, 32'h100,      0, 32'h0);
      rows[19] = mk(0, 0, 32'h0,        1, 32'h104,      1, 32'h104);
      rows[20] = mk(1, 1, 32'h200,      1, 32'h108,      1, 32'h108);
      rows[21] = mk(0, 0, 32'h0,        1, 32'h200,      0, 32'h0);
      rows[22] = mk(0, 1, 32'hFFFFFFFC, 1, 32'h204,      1, 32'h204);
      rows[23] = mk(0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0);
      rows[24] = mk(0, 0, 32'h0,        1, 32'h0,        1, 32'h0);
      rows[25] = mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h4);
      // 3 wait states: redirect one cycle into the 0x10 fetch
      rows[26] = mk(0, 1, 32'h40,       1, 32'h10,       0, 32'h0);
      rows[27] = mk(0, 0, 32'h0,        1, 32'h10,       0, 32'h0);
      rows[28] = mk(0, 0, 32'h0,        1, 32'h10,       0, 32'h0);
      rows[29] = mk(0, 0, 32'h0,        1, 32'h40,       0, 32'h0);
      rows[30] = mk(0, 0, 32'h0,        1, 32'h40,       0, 32'h0);
      rows[31] = mk(0, 0, 32'h0,        1, 32'h40,       0, 32'h0);
      rows[32] = mk(0, 0, 32'h0,        1, 32'h40,       0, 32'h0);
      rows[33] = mk(0, 0, 32'h0,        1, 32'h44,       1, 32'h44);
      // Two redirects during one pending fetch; freeze leaves one entry queued
      rows[34] = mk(0, 1, 32'h20,       1, 32'h44,       0, 32'h0);
      rows[35] = mk(0, 1, 32'h60,       1, 32'h44,       0, 32'h0);
      rows[36] = mk(0, 0, 32'h0,        1, 32'h44,       0, 32'h0);
      rows[37] = mk(0, 0, 32'h0,        1, 32'h60,       0, 32'h0);
      rows[38] = mk(0, 0, 32'h0,        1, 32'h60,       0, 32'h0);
      rows[39] = mk(0, 0, 32'h0,        1, 32'h60,       0, 32'h0);
      rows[40] = mk(0, 0, 32'h0,        1, 32'h60,       0, 32'h0);
      rows[41] = mk(1, 0, 32'h0,        1, 32'h64,       1, 32'h64);
      rows[42] = mk(1, 0, 32'h0,        1, 32'h64,       1, 32'h64);
      // Restart after mid-fetch reset
      rows[43] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
      rows[44] = mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
      rows[45] = mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
      rows[46] = mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
      rows[47] = mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
      rows[48] = mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h4);

      mem_wait = 0;
      apply_reset("por");
      run_rows(0, 25);

      mem_wait = 3;
      apply_reset("reset2");
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         #1;
         if (imem_req && imem_addr == 32'h10) found = 1'b1;
      end
      chk("sync fetch 0x10", {31'd0, found}, 32'd1);
      run_rows(26, 42);

      apply_reset("midfetch");
      run_rows(43, 48);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
